// File: rtl/audio_sample_gain.sv
// ============================================================================
// Module   : audio_sample_gain
// Purpose  : Two-stage stereo gain/mute/saturate path from ADC FWFT FIFO to DAC
//            FIFO with full backpressure. Optional peak meter: AUDIO_GAIN_PEAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_sample_gain #(
    parameter int DW = 16,
    parameter int GW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [GW-1:0]   gain_l,
    input  logic [GW-1:0]   gain_r,
    input  logic            mute,
    input  logic [2*DW-1:0] adc_data_out,
    input  logic            adc_fifo_empty,
    output logic            adc_data_rd,
    output logic [2*DW-1:0] dac_data_in,
    output logic            dac_data_wr,
`ifdef AUDIO_GAIN_PEAK_EN
    input  logic            dac_fifo_full,
    output logic [DW-2:0]   peak_l,
    output logic [DW-2:0]   peak_r,
    input  logic            peak_clr
`else
    input  logic            dac_fifo_full
`endif
);

    localparam int FRAC = 4;
    localparam int PW   = DW + GW + 1;

    logic            s1_valid;
    logic [2*DW-1:0] s1_data;
    logic [GW-1:0]   s1_gain_l;
    logic [GW-1:0]   s1_gain_r;
    logic            s1_mute;
    logic            s2_valid;
    logic [2*DW-1:0] s2_data;

    logic            stall;
    logic            s1_load;
    logic [DW-1:0]   res_l;
    logic [DW-1:0]   res_r;

    // Equal-width unsigned multiply of sign-extended operands yields the
    // correct two's-complement product in the low PW bits.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s, input logic [GW-1:0] g);
        logic [PW-1:0]        a;
        logic [PW-1:0]        b;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] sh;
        a    = {{(GW+1){s[DW-1]}}, s};
        b    = {{(DW+1){1'b0}}, g};
        prod = $signed(a * b);
        sh   = prod >>> FRAC;
        if ((&sh[PW-1:DW-1]) || !(|sh[PW-1:DW-1]))
            scale = sh[DW-1:0];
        else if (sh[PW-1])
            scale = {1'b1, {(DW-1){1'b0}}};
        else
            scale = {1'b0, {(DW-1){1'b1}}};
    endfunction

    assign stall       = s2_valid & dac_fifo_full;
    assign s1_load     = ~s1_valid | ~stall;
    assign dac_data_wr = s2_valid & ~dac_fifo_full;
    // Gated by reset so no pop is signalled while the pipeline is held cleared.
    assign adc_data_rd = rst & enable & ~adc_fifo_empty & s1_load;
    assign dac_data_in = s2_data;

    assign res_l = s1_mute ? '0 : scale(s1_data[2*DW-1:DW], s1_gain_l);
    assign res_r = s1_mute ? '0 : scale(s1_data[DW-1:0],    s1_gain_r);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_gain_l <= '0;
            s1_gain_r <= '0;
            s1_mute   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= adc_data_rd;
                if (adc_data_rd) begin
                    s1_data   <= adc_data_out;
                    s1_gain_l <= gain_l;
                    s1_gain_r <= gain_r;
                    s1_mute   <= mute;
                end
            end
            if (!stall) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    s2_data <= {res_l, res_r};
            end
        end
    end

`ifdef AUDIO_GAIN_PEAK_EN
    logic [DW-2:0] mag_l;
    logic [DW-2:0] mag_r;

    // The most negative code has no positive counterpart and clamps to full scale.
    function automatic logic [DW-2:0] magnitude(input logic [DW-1:0] v);
        logic [DW-2:0] neg;
        neg = ~v[DW-2:0] + {{(DW-2){1'b0}}, 1'b1};
        if (!v[DW-1])
            magnitude = v[DW-2:0];
        else if (v[DW-2:0] == '0)
            magnitude = '1;
        else
            magnitude = neg;
    endfunction

    assign mag_l = magnitude(s2_data[2*DW-1:DW]);
    assign mag_r = magnitude(s2_data[DW-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_l <= '0;
            peak_r <= '0;
        end else if (peak_clr) begin
            peak_l <= '0;
            peak_r <= '0;
        end else if (dac_data_wr) begin
            if (mag_l > peak_l) peak_l <= mag_l;
            if (mag_r > peak_r) peak_r <= mag_r;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_gain.sv
// Scoreboard bench for audio_sample_gain: FWFT ADC FIFO model feeds the DUT,
// expected words are queued at push time and checked on every DAC write.
`default_nettype none

module tb_audio_sample_gain;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        enable    = 1'b0;
    logic        mute      = 1'b0;
    logic        dac_full  = 1'b0;
    logic [7:0]  gain_l    = 8'h10;
    logic [7:0]  gain_r    = 8'h10;
    logic        adc_empty = 1'b1;
    logic [31:0] adc_head  = 32'h0;
    logic        rd;
    logic        wr;
    logic [31:0] dac_in;
`ifdef AUDIO_GAIN_PEAK_EN
    logic        peak_clr  = 1'b0;
    logic [14:0] peak_l;
    logic [14:0] peak_r;
`endif

    logic [31:0] adc_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int total = 0, bad = 0, cyc = 0, pop_count = 0, wr_count = 0;
    int pop_c = 0, lat_pop = 0, lat_wr = 0, p0 = 0, w0 = 0;
    bit pop_p = 0, arm_lat = 0, got_pop = 0, got_wr = 0;

    audio_sample_gain #(.DW(16), .GW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .gain_l         (gain_l),
        .gain_r         (gain_r),
        .mute           (mute),
        .adc_data_out   (adc_head),
        .adc_fifo_empty (adc_empty),
        .adc_data_rd    (rd),
        .dac_data_in    (dac_in),
        .dac_data_wr    (wr),
`ifdef AUDIO_GAIN_PEAK_EN
        .dac_fifo_full  (dac_full),
        .peak_l         (peak_l),
        .peak_r         (peak_r),
        .peak_clr       (peak_clr)
`else
        .dac_fifo_full  (dac_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic refresh();
        adc_empty = (adc_q.size() == 0);
        adc_head  = adc_empty ? 32'h0 : adc_q[0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] din, input logic [31:0] e);
        adc_q.push_back(din);
        exp_q.push_back(e);
        refresh();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || adc_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic run_vec(input string name, input logic [7:0] gl, input logic [7:0] gr,
                           input logic [31:0] din, input logic [31:0] e);
        gain_l = gl;
        gain_r = gr;
        push(din, e);
        wait_idle(name);
    endtask

    // FIFO model: pop decided from the pre-edge read strobe, applied just after.
    always @(posedge clk) begin
        pop_p = (rd === 1'b1);
        pop_c = cyc;
        cyc++;
        #1;
        if (pop_p) begin
            void'(adc_q.pop_front());
            pop_count++;
            if (arm_lat && !got_pop) begin
                got_pop = 1;
                lat_pop = pop_c;
            end
            refresh();
        end
    end

    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wr_count++;
            if (arm_lat && !got_wr) begin
                got_wr = 1;
                lat_wr = cyc;
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %h expected none", dac_in);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dac_word", dac_in, mon_exp);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        refresh();
        repeat (3) tick();
        check("rst_wr", wr, 0);
        check("rst_rd", rd, 0);
        check("rst_dout", dac_in, 0);
`ifdef AUDIO_GAIN_PEAK_EN
        check("rst_peak_l", peak_l, 0);
        check("rst_peak_r", peak_r, 0);
`endif
        rst    = 1'b1;
        enable = 1'b1;
        tick();

        // Unity passthrough and pop-to-write latency
        arm_lat = 1;
        push(32'h7FFF8000, 32'h7FFF8000);
        push(32'h00010002, 32'h00010002);
        push(32'h1234ABCD, 32'h1234ABCD);
        wait_idle("unity");
        check("latency", lat_wr - lat_pop, 2);
        arm_lat = 0;

        run_vec("sat_scale",  8'h20, 8'h08, 32'h4000C001, 32'h7FFFE000);
        run_vec("half_trunc", 8'h08, 8'h08, 32'h00030003, 32'h00010001);
        run_vec("gain_zero",  8'h00, 8'h00, 32'h7FFF8000, 32'h00000000);
        run_vec("gain_max",   8'hFF, 8'hFF, 32'h80007FFF, 32'h80007FFF);
        run_vec("floor_neg",  8'h18, 8'h18, 32'hFFFF0064, 32'hFFFE0096);
        run_vec("mixed",      8'hFF, 8'h10, 32'h7FFF8000, 32'h7FFF8000);

        // Backpressure mid-stream
        gain_l = 8'h10;
        gain_r = 8'h10;
        for (int i = 1; i <= 8; i++) push(32'h01010101 * i, 32'h01010101 * i);
        repeat (3) tick();
        dac_full = 1'b1;
        p0 = pop_count;
        w0 = wr_count;
        repeat (10) tick();
        check("bp_pops_le2", (pop_count - p0) <= 2, 1);
        check("bp_no_write", wr_count - w0, 0);
        dac_full = 1'b0;
        wait_idle("backpressure");

        // Mute
        mute = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h5A5AA5A5 + i, 32'h0);
        wait_idle("mute");
        mute = 1'b0;

        // Enable drop: two samples in flight drain, the rest stay queued
        w0 = wr_count;
        for (int i = 0; i < 4; i++) push(32'h00100010 * (i + 1), 32'h00100010 * (i + 1));
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("en_off_rd", rd, 0);
        end
        check("en_off_writes", wr_count - w0, 2);
        check("en_off_fifo", adc_q.size(), 2);
        enable = 1'b1;
        wait_idle("enable");

        // Reset mid-stream with both stages loaded
        dac_full = 1'b1;
        push(32'h11112222, 32'h11112222);
        push(32'h33334444, 32'h33334444);
        push(32'h55556666, 32'h55556666);
        repeat (4) tick();
        dac_full = 1'b0;
        #1;
        check("pre_rst_wr", wr, 1);
        check("pre_rst_rd", rd, 1);
        rst = 1'b0;
        #1;
        check("rst_async_wr", wr, 0);
        check("rst_async_rd", rd, 0);
        exp_q.delete();
        adc_q.delete();
        refresh();
        tick();
        tick();
        check("rst_mid_dout", dac_in, 0);
        rst = 1'b1;
        tick();
        push(32'h0ABC0DEF, 32'h0ABC0DEF);
        wait_idle("post_reset");

`ifdef AUDIO_GAIN_PEAK_EN
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        push(32'h10000F00, 32'h10000F00);
        push(32'h80000100, 32'h80000100);
        wait_idle("peak");
        check("peak_l", peak_l, 15'h7FFF);
        check("peak_r", peak_r, 15'h0F00);
        dac_full = 1'b1;
        push(32'h7000F000, 32'h7000F000);
        repeat (4) tick();
        dac_full = 1'b0;
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        check("clr_peak_l", peak_l, 0);
        check("clr_peak_r", peak_r, 0);
        wait_idle("peak_clr");
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
